// File: rtl/cxu_pkg.sv
// Shared CXU definitions: status codes, id-width helpers, response entry layout
// and the parameter legality check used by the L0->L2 pipelined adapter.
package cxu_pkg;

    localparam int CXU_STATUS_W    = 3;
    localparam int CXU_RESP_DATA_W = 32;

    typedef enum logic [CXU_STATUS_W-1:0] {
        CXU_OK           = 3'd0,
        CXU_ERROR_CXU    = 3'd1,
        CXU_ERROR_OP     = 3'd2,
        CXU_ERROR_STATE  = 3'd3,
        CXU_ERROR_CUSTOM = 3'd4
    } cxu_status_e;

    // Response entry at the default 32-bit data width.
    typedef struct packed {
        logic [CXU_STATUS_W-1:0]    status;
        logic [CXU_RESP_DATA_W-1:0] data;
    } resp_entry_t;

    // Id field width for n ids; never narrower than one bit.
    function automatic int cxu_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Declared widths of 0 still need a one-bit port.
    function automatic int cxu_eff_w(input int w);
        return (w < 1) ? 1 : w;
    endfunction

    // Only stateless targets and non-degenerate pipe/queue sizes are legal.
    function automatic bit check_param(input int n_states, input int pipe, input int depth);
        return (n_states == 0) && (pipe >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/cxu_resp_fifo.sv
// Response queue: DEPTH entries of W bits, any depth (pointers wrap modulo DEPTH).
// Push and pop in the same cycle at full is legal. No bypass: a push to an empty
// queue becomes visible on the following cycle.
module cxu_resp_fifo #(
    parameter int DEPTH = 1,
    parameter int W     = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= nxt(wr_q);
            if (do_pop)  rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; entries are only read once written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (do_push && wr_q == PW'(i)) mem_q[i] <= wdata_i;
    end

    // Head entry select.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rd_q == PW'(i)) rdata_o = mem_q[i];
    end

endmodule

// File: rtl/cvt02_pipe_cxu.sv
// CXU-L0 -> L2 adapter with fixed PIPE_STAGES response latency and a RESP_DEPTH
// response queue. Credits cover in-flight stages plus queued entries, so the
// queue never overflows. Optional perf counters: CVT02_PIPE_CXU_PERF_EN.
module cvt02_pipe_cxu
    import cxu_pkg::*;
#(
    parameter int CXU_N_CXUS     = 1,
    parameter int CXU_N_STATES   = 0,
    parameter int CXU_FUNC_ID_W  = 0,
    parameter int CXU_INSN_W     = 0,
    parameter int CXU_DATA_W     = 32,
    parameter int PIPE_STAGES    = 1,
    parameter int RESP_DEPTH     = 1,
    localparam int CXU_CXU_ID_W   = cxu_id_w(CXU_N_CXUS),
    localparam int CXU_STATE_ID_W = cxu_id_w(CXU_N_STATES),
    localparam int FUNC_W         = cxu_eff_w(CXU_FUNC_ID_W),
    localparam int INSN_W         = cxu_eff_w(CXU_INSN_W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CXU_CXU_ID_W-1:0]   req_cxu,
    input  logic [CXU_STATE_ID_W-1:0] req_state,
    input  logic [FUNC_W-1:0]         req_func,
    input  logic [INSN_W-1:0]         req_insn,
    input  logic [CXU_DATA_W-1:0]     req_data0,
    input  logic [CXU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [CXU_STATUS_W-1:0]   resp_status,
    output logic [CXU_DATA_W-1:0]     resp_data,
    output logic                      t_req_valid,
    output logic [CXU_CXU_ID_W-1:0]   t_req_cxu,
    output logic [FUNC_W-1:0]         t_req_func,
    output logic [CXU_DATA_W-1:0]     t_req_data0,
    output logic [CXU_DATA_W-1:0]     t_req_data1,
    input  logic [CXU_STATUS_W-1:0]   t_resp_status,
    input  logic [CXU_DATA_W-1:0]     t_resp_data
`ifdef CVT02_PIPE_CXU_PERF_EN
    ,
    output logic [31:0]               perf_resps,
    output logic [31:0]               perf_stalls
`endif
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int NSTG  = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    typedef struct packed {
        logic [CXU_STATUS_W-1:0] status;
        logic [CXU_DATA_W-1:0]   data;
    } entry_t;

    if (!check_param(CXU_N_STATES, PIPE_STAGES, RESP_DEPTH)) begin : g_bad_param
        $error("cvt02_pipe_cxu: needs CXU_N_STATES==0, PIPE_STAGES>=1, RESP_DEPTH>=1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_hs, resp_hs, fifo_push, fifo_empty;
    entry_t           fifo_wdata, fifo_rdata;
    logic             unused_full, unused_req;
    logic [CNT_W-1:0] unused_count;

    assign unused_req  = ^{req_state, req_insn};

    // Target sees the request combinationally; it answers in the same cycle.
    assign t_req_valid = req_valid;
    assign t_req_cxu   = req_cxu;
    assign t_req_func  = req_func;
    assign t_req_data0 = req_data0;
    assign t_req_data1 = req_data1;

    assign resp_valid  = !fifo_empty;
    assign resp_status = fifo_rdata.status;
    assign resp_data   = fifo_rdata.data;
    assign resp_hs     = clk_en && resp_valid && resp_ready;
    // A same-cycle pop frees a credit, hence the resp_ready -> req_ready path.
    assign req_ready   = clk_en && ((cnt_q < CNT_W'(RESP_DEPTH)) || (resp_valid && resp_ready));
    assign req_hs      = req_valid && req_ready;

    if (PIPE_STAGES == 1) begin : g_direct
        assign fifo_push  = req_hs;
        assign fifo_wdata = {t_resp_status, t_resp_data};
    end else begin : g_pipe
        logic   [NSTG-1:0] vld_q;
        entry_t [NSTG-1:0] ent_q;

        // Sampled target response travels one stage per enabled cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                ent_q <= '0;
            end else if (clk_en) begin
                vld_q[0] <= req_hs;
                ent_q[0] <= {t_resp_status, t_resp_data};
                for (int i = 1; i < NSTG; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    ent_q[i] <= ent_q[i-1];
                end
            end
        end

        assign fifo_push  = clk_en && vld_q[NSTG-1];
        assign fifo_wdata = ent_q[NSTG-1];
    end

    // Credit next-state: request adds, response removes, both cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (req_hs && !resp_hs)      cnt_d = cnt_q + CNT_W'(1);
        else if (!req_hs && resp_hs) cnt_d = cnt_q - CNT_W'(1);
    end

    // Credit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    cxu_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .W     ($bits(entry_t))
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (resp_hs),
        .rdata_o (fifo_rdata),
        .full_o  (unused_full),
        .empty_o (fifo_empty),
        .count_o (unused_count)
    );

`ifdef CVT02_PIPE_CXU_PERF_EN
    logic [31:0] perf_resps_q, perf_stalls_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_resps_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (resp_hs)                            perf_resps_q  <= perf_resps_q + 32'd1;
            if (clk_en && req_valid && !req_ready)  perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_resps  = perf_resps_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/cvt02_pipe_cxu.md
Name: cvt02_pipe_cxu

Overview:
- CXU-L0 to CXU-L2 feature level adapter with configurable fixed response latency (PIPE_STAGES) and a buffered response queue (RESP_DEPTH).
- Adapts L2 requests to a subordinate combinational L0 CXU and sends its responses on the L2 side.
- Sustains one request per cycle under response backpressure, using credit accounting.
- PIPE_STAGES=1, RESP_DEPTH=1 is cycle-equivalent to the existing one-cycle L0→L2 adapter.

Parameters:
- CXU_N_CXUS, 1: number of CXU ids; CXU_CXU_ID_W = max(1, clog2(CXU_N_CXUS)).
- CXU_N_STATES, 0: must be 0 (stateless target); any other value is rejected by check_param.
- CXU_FUNC_ID_W, 0: function id width; an effective width of 0 maps to 1.
- CXU_INSN_W, 0: raw instruction width; ignored.
- CXU_DATA_W, 32: operand and result width.
- PIPE_STAGES, 1: request-to-response latency in cycles; must be ≥1.
- RESP_DEPTH, 1: maximum in-flight plus queued responses; must be ≥1; full throughput requires RESP_DEPTH ≥ PIPE_STAGES+1 under stalls.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  clock enable; no state advances while low.
- req_valid  input  1  L2 request valid.
- req_ready  output  1  L2 request ready.
- req_cxu  input  CXU_CXU_ID_W  CXU id.
- req_state  input  CXU_STATE_ID_W  state id; unused.
- req_func  input  CXU_FUNC_ID_W  function id.
- req_insn  input  CXU_INSN_W  instruction; unused.
- req_data0  input  CXU_DATA_W  operand 0.
- req_data1  input  CXU_DATA_W  operand 1.
- resp_valid  output  1  L2 response valid.
- resp_ready  input  1  L2 response ready.
- resp_status  output  CXU_STATUS_W  response status.
- resp_data  output  CXU_DATA_W  response data.
- t_req_valid  output  1  L0 target request valid.
- t_req_cxu  output  CXU_CXU_ID_W  to target.
- t_req_func  output  CXU_FUNC_ID_W  to target.
- t_req_data0  output  CXU_DATA_W  to target.
- t_req_data1  output  CXU_DATA_W  to target.
- t_resp_status  input  CXU_STATUS_W  from target, combinational.
- t_resp_data  input  CXU_DATA_W  from target, combinational.

Behaviour:
- Reset (async, rst_n low): pipeline valids=0, FIFO empty, credit count=0, resp_valid=0. resp_status/resp_data are don't-care.
- Target interface:
  - t_req_* = req_* combinationally, including t_req_valid = req_valid.
  - t_resp_* is sampled at the request handshake.
- Handshakes:
  - Request handshake = clk_en && req_valid && req_ready.
  - Response handshake = clk_en && resp_valid && resp_ready.
- Credit count: cnt = in-flight stage valids + FIFO occupancy, range 0..RESP_DEPTH.
- req_ready = clk_en && (cnt < RESP_DEPTH || (resp_valid && resp_ready)).
  - Same-cycle pop frees a slot: a combinational path from resp_ready to req_ready is intended.
- Pipeline:
  - PIPE_STAGES-1 registered stages {valid, status, data} shift on each clk_en cycle.
  - The final stage, or the handshake directly when PIPE_STAGES=1, writes the FIFO.
- Latency:
  - Request handshaken at edge t with the FIFO empty → resp_valid=1 from edge t+PIPE_STAGES, carrying the sampled status/data.
  - Responses are strictly in request order.
- FIFO:
  - resp_valid = !empty; resp_status/resp_data = head entry, held stable while resp_valid && !resp_ready.
  - Simultaneous push and pop at full: legal; occupancy unchanged.
  - Push to empty with no same-cycle pop: visible the next cycle. There is no bypass, so latency stays fixed.
  - Pointers wrap modulo RESP_DEPTH; any depth, including non-power-of-2, is supported.
- Credit update: cnt += request handshake; cnt -= response handshake. Both in the same cycle → unchanged.
- clk_en low:
  - req_ready=0, no shift, no pop counted.
  - resp_valid and head data hold.
- Reset mid-operation discards all in-flight and queued responses; the target is stateless, so no cleanup is needed.
- Error statuses from the target pass through unmodified.

Optional Feature:
- CVT02_PIPE_CXU_PERF_EN. When defined, adds two outputs:
  - perf_resps (32b): count of response handshakes.
  - perf_stalls (32b): cycles with clk_en && req_valid && !req_ready.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- cxu_pkg: CXU_STATUS_W and status enum, id width helpers, a resp_entry_t struct {status, data} parameterised via localparam widths. Existing L2/L0 port macros are reused.
- Sub-module cxu_resp_fifo:
  - Parameters: DEPTH, W.
  - Interface: push/pop/full/empty/count, with async active-low reset.
  - Instantiated once for the response queue.

Test Plan:
- Default params, target returns data0+data1: req 3,4 at cycle 0 with resp_ready=1 → resp_valid at cycle 1, data=7, status OK; back-to-back requests give one response per cycle.
- PIPE_STAGES=3, RESP_DEPTH=4: requests at cycles 0,1,2 → responses at cycles 3,4,5 in order with matching data.
- PIPE_STAGES=2, RESP_DEPTH=3, resp_ready=0: 3 requests accepted, 4th sees req_ready=0; raise resp_ready → same cycle req_ready=1, cnt stays 3.
- clk_en toggled 0 for 2 cycles mid-stream → no state advance, outputs held, latency extended by exactly 2.
- rst_n pulsed low with 2 in flight → resp_valid=0 immediately (async); no stale response after release.
- PERF_EN, RESP_DEPTH=1, resp_ready=0 for 5 cycles with req_valid=1 → perf_stalls=4 (cycles 1–4), perf_resps=1 after release.
